// File: rtl/fish_pkg.sv
// Shared constants and types for the fish sprite overlay path.
// Geometry, motion rates and the chroma-key colour live here so the pipeline and counters agree.
package fish_pkg;
   localparam int VBUF_W      = 320;
   localparam int FISH_W      = 64;
   localparam int FISH_H      = 32;
   localparam int FISH_FRAMES = 8;
   localparam int FISH_Y      = 64;
   localparam int SPEED       = 1;
   localparam int FRAME_DIV   = 8;

   typedef logic [11:0] texel_t;

   localparam texel_t KEY_COLOR = 12'h0F0;
endpackage

// File: rtl/fish_sprite_engine_if.sv
// Pixel stream in, sprite SRAM port and composited pixel out for the fish sprite engine.
// The engine takes the slave side; the video source, SRAM and display sink take the master side.
interface fish_sprite_engine_if #(
   parameter int DATA_WIDTH = 12,
   parameter int ADDR_WIDTH = 16
);
   logic [9:0]            pixel_x;
   logic [9:0]            pixel_y;
   logic                  video_on;
   logic [DATA_WIDTH-1:0] bg_rgb;
   logic [ADDR_WIDTH-1:0] sram_addr;
   logic                  sram_en;
   logic                  sram_we;
   logic [DATA_WIDTH-1:0] sram_data;
   logic [DATA_WIDTH-1:0] rgb_o;
   logic                  video_on_o;

   modport master (
      output pixel_x, pixel_y, video_on, bg_rgb, sram_data,
      input  sram_addr, sram_en, sram_we, rgb_o, video_on_o
   );

   modport slave (
      input  pixel_x, pixel_y, video_on, bg_rgb, sram_data,
      output sram_addr, sram_en, sram_we, rgb_o, video_on_o
   );
endinterface

// File: rtl/fish_anim_ctrl.sv
// Per-frame fish motion: divides frame_tick down, then steps x position and animation frame.
// Updates on the tick clock edge; no backpressure, counters simply hold while run is low.
module fish_anim_ctrl
   import fish_pkg::*;
#(
   parameter int VBUF_W      = fish_pkg::VBUF_W,
   parameter int FISH_FRAMES = fish_pkg::FISH_FRAMES,
   parameter int SPEED       = fish_pkg::SPEED,
   parameter int FRAME_DIV   = fish_pkg::FRAME_DIV,
   localparam int XW = $clog2(VBUF_W),
   localparam int FW = (FISH_FRAMES > 1) ? $clog2(FISH_FRAMES) : 1,
   localparam int DW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          run,
   input  logic          frame_tick,
   output logic [XW-1:0] fish_x,
   output logic [FW-1:0] frame_idx
);
   logic [DW-1:0] div_cnt;
   logic [XW:0]   x_sum;
   logic [XW-1:0] x_next;
   logic          step;

   assign step = (div_cnt == DW'(FRAME_DIV - 1));

   // x wraps at the scaled frame width so the fish re-enters from the left edge
   always_comb begin
      x_sum  = {1'b0, fish_x} + (XW+1)'(SPEED);
      x_next = (x_sum >= (XW+1)'(VBUF_W)) ? XW'(x_sum - (XW+1)'(VBUF_W)) : XW'(x_sum);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div_cnt   <= '0;
         frame_idx <= '0;
         fish_x    <= '0;
      end else if (frame_tick && run) begin
         if (step) begin
            div_cnt   <= '0;
            frame_idx <= (frame_idx == FW'(FISH_FRAMES - 1)) ? '0 : frame_idx + 1'b1;
            fish_x    <= x_next;
         end else begin
            div_cnt <= div_cnt + 1'b1;
         end
      end
   end
endmodule

// File: rtl/fish_sprite_engine.sv
// Overlays the animated fish sprite on the background with a chroma key.
// 3 clk from pixel inputs to rgb_o, sprite read address registered at stage 1; never stalls.
module fish_sprite_engine
   import fish_pkg::*;
#(
   parameter int DATA_WIDTH  = 12,
   parameter int ADDR_WIDTH  = 16,
   parameter int VBUF_W      = fish_pkg::VBUF_W,
   parameter int FISH_W      = fish_pkg::FISH_W,
   parameter int FISH_H      = fish_pkg::FISH_H,
   parameter int FISH_FRAMES = fish_pkg::FISH_FRAMES,
   parameter int FISH_Y      = fish_pkg::FISH_Y,
   parameter int SPEED       = fish_pkg::SPEED,
   parameter int FRAME_DIV   = fish_pkg::FRAME_DIV,
   parameter logic [DATA_WIDTH-1:0] KEY_COLOR = fish_pkg::KEY_COLOR,
   localparam int XW = $clog2(VBUF_W),
   localparam int FW = (FISH_FRAMES > 1) ? $clog2(FISH_FRAMES) : 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 run,
   input  logic                 frame_tick,
   fish_sprite_engine_if.slave  bus
);
   logic [XW-1:0]         fish_x;
   logic [FW-1:0]         frame_idx;

   logic [9:0]            vx;
   logic [9:0]            vy;
   logic [9:0]            fx;
   logic [9:0]            col;
   logic [9:0]            row;
   logic                  hit;
   logic [ADDR_WIDTH-1:0] addr;

   logic [ADDR_WIDTH-1:0] sram_addr_q;
   logic                  hit_s1, vid_s1, hit_s2, vid_s2;
   logic [DATA_WIDTH-1:0] bg_s1, bg_s2;
   logic [DATA_WIDTH-1:0] rgb_q;
   logic                  vid_q;

   fish_anim_ctrl #(
      .VBUF_W      (VBUF_W),
      .FISH_FRAMES (FISH_FRAMES),
      .SPEED       (SPEED),
      .FRAME_DIV   (FRAME_DIV)
   ) u_anim (
      .clk        (clk),
      .reset_n    (reset_n),
      .run        (run),
      .frame_tick (frame_tick),
      .fish_x     (fish_x),
      .frame_idx  (frame_idx)
   );

   // Column is taken modulo the frame width so a box straddling the right edge shows on the left
   always_comb begin
      vx   = bus.pixel_x >> 1;
      vy   = bus.pixel_y >> 1;
      fx   = 10'(fish_x);
      col  = (vx >= fx) ? (vx - fx) : (vx + 10'(VBUF_W) - fx);
      row  = vy - 10'(FISH_Y);
      hit  = bus.video_on && (col < 10'(FISH_W)) &&
             (vy >= 10'(FISH_Y)) && (vy < 10'(FISH_Y + FISH_H));
      addr = ADDR_WIDTH'(frame_idx) * ADDR_WIDTH'(FISH_W * FISH_H)
           + ADDR_WIDTH'(row) * ADDR_WIDTH'(FISH_W)
           + ADDR_WIDTH'(col);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sram_addr_q <= '0;
         hit_s1      <= 1'b0;
         vid_s1      <= 1'b0;
         bg_s1       <= '0;
         hit_s2      <= 1'b0;
         vid_s2      <= 1'b0;
         bg_s2       <= '0;
         rgb_q       <= '0;
         vid_q       <= 1'b0;
      end else begin
         sram_addr_q <= hit ? addr : '0;
         hit_s1      <= hit;
         vid_s1      <= bus.video_on;
         bg_s1       <= bus.bg_rgb;
         // stage 2 lines up with the texel arriving from SRAM
         hit_s2      <= hit_s1;
         vid_s2      <= vid_s1;
         bg_s2       <= bg_s1;
         vid_q       <= vid_s2;
         if (!vid_s2)
            rgb_q <= '0;
         else if (hit_s2 && (bus.sram_data != KEY_COLOR))
            rgb_q <= bus.sram_data;
         else
            rgb_q <= bg_s2;
      end
   end

   assign bus.sram_addr  = sram_addr_q;
   assign bus.sram_en    = 1'b1;
   assign bus.sram_we    = 1'b0;
   assign bus.rgb_o      = rgb_q;
   assign bus.video_on_o = vid_q;
endmodule

// File: tb/tb_fish_sprite_engine.sv
// Directed bench for fish_sprite_engine with a behavioural sprite SRAM (1 clk read latency).
module tb_fish_sprite_engine;
   import fish_pkg::*;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic run = 1'b0;
   logic frame_tick = 1'b0;
   int   total = 0;
   int   bad = 0;

   fish_sprite_engine_if bus ();

   fish_sprite_engine dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .run        (run),
      .frame_tick (frame_tick),
      .bus        (bus)
   );

   always #5 clk = ~clk;

   texel_t mem [0:16383];

   function automatic texel_t tex(input int a);
      if (a == 69) return 12'hABC;
      if (a == 70) return 12'h0F0;
      return {4'hF, 8'(a)};
   endfunction

   always @(posedge clk) bus.sram_data <= mem[bus.sram_addr[13:0]];

   task automatic cyc(input int x, input int y, input logic von, input texel_t bg);
      bus.pixel_x  = 10'(x);
      bus.pixel_y  = 10'(y);
      bus.video_on = von;
      bus.bg_rgb   = bg;
      @(posedge clk);
      #1;
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         frame_tick = 1'b1;
         cyc(0, 0, 1'b0, 12'h000);
         frame_tick = 1'b0;
      end
   endtask

   task automatic test_reset;
      run = 1'b1;
      for (int i = 0; i < 6; i++) begin
         frame_tick = i[0];
         cyc(i * 37 + 10, i * 53 + 128, 1'b1, 12'(i * 291 + 5));
         total++;
         if (bus.rgb_o !== 12'h000) begin bad++; $display("FAIL reset_rgb got %h exp 000", bus.rgb_o); end
         total++;
         if (bus.video_on_o !== 1'b0) begin bad++; $display("FAIL reset_vo got %b exp 0", bus.video_on_o); end
         total++;
         if (bus.sram_addr !== 16'h0000) begin bad++; $display("FAIL reset_addr got %h exp 0000", bus.sram_addr); end
      end
      total++;
      if (bus.sram_en !== 1'b1 || bus.sram_we !== 1'b0) begin
         bad++; $display("FAIL sram_ctl got en=%b we=%b exp en=1 we=0", bus.sram_en, bus.sram_we);
      end
      total++;
      if (dut.u_anim.fish_x !== 9'd0 || dut.u_anim.frame_idx !== 3'd0) begin
         bad++; $display("FAIL reset_motion got x=%0d f=%0d exp x=0 f=0", dut.u_anim.fish_x, dut.u_anim.frame_idx);
      end
      frame_tick = 1'b0;
      run = 1'b0;
      reset_n = 1'b1;
   endtask

   task automatic test_hit_addr;
      cyc(10, 130, 1'b1, 12'h111);
      total++;
      if (bus.sram_addr !== 16'd69) begin bad++; $display("FAIL hit_addr got %0d exp 69", bus.sram_addr); end
      cyc(0, 0, 1'b0, 12'h000);
      cyc(0, 0, 1'b0, 12'h000);
      total++;
      if (bus.rgb_o !== 12'hABC || bus.video_on_o !== 1'b1) begin
         bad++; $display("FAIL hit_rgb got %h/%b exp ABC/1", bus.rgb_o, bus.video_on_o);
      end
   endtask

   typedef struct {
      int     x;
      int     y;
      logic   von;
      texel_t bg;
      int     addr;
      texel_t rgb;
   } vec_t;

   // back-to-back pixels with fish at x=0, frame 0: key, miss, interior, blank, box edges
   task automatic test_back_to_back;
      vec_t v [9];
      v = '{
         '{12,  130, 1'b1, 12'h123, 70,   12'h123},
         '{0,   0,   1'b1, 12'h456, 0,    12'h456},
         '{20,  140, 1'b1, 12'h321, 394,  12'hF8A},
         '{10,  130, 1'b0, 12'h777, 0,    12'h000},
         '{0,   190, 1'b1, 12'h222, 1984, 12'hFC0},
         '{126, 190, 1'b1, 12'h333, 2047, 12'hFFF},
         '{128, 130, 1'b1, 12'h444, 0,    12'h444},
         '{0,   192, 1'b1, 12'h555, 0,    12'h555},
         '{0,   126, 1'b1, 12'h666, 0,    12'h666}
      };
      for (int k = 0; k < 11; k++) begin
         if (k < 9) cyc(v[k].x, v[k].y, v[k].von, v[k].bg);
         else       cyc(0, 0, 1'b0, 12'h000);
         if (k < 9) begin
            total++;
            if (bus.sram_addr !== 16'(v[k].addr)) begin
               bad++; $display("FAIL b2b_addr[%0d] got %0d exp %0d", k, bus.sram_addr, v[k].addr);
            end
         end
         if (k >= 2) begin
            total++;
            if (bus.rgb_o !== v[k-2].rgb || bus.video_on_o !== v[k-2].von) begin
               bad++; $display("FAIL b2b_rgb[%0d] got %h/%b exp %h/%b", k - 2, bus.rgb_o, bus.video_on_o, v[k-2].rgb, v[k-2].von);
            end
         end
      end
   endtask

   task automatic test_freeze;
      run = 1'b0;
      tick(16);
      total++;
      if (dut.u_anim.fish_x !== 9'd0 || dut.u_anim.frame_idx !== 3'd0) begin
         bad++; $display("FAIL freeze got x=%0d f=%0d exp x=0 f=0", dut.u_anim.fish_x, dut.u_anim.frame_idx);
      end
      cyc(10, 130, 1'b1, 12'h000);
      total++;
      if (bus.sram_addr !== 16'd69) begin bad++; $display("FAIL freeze_addr got %0d exp 69", bus.sram_addr); end
   endtask

   task automatic test_motion;
      run = 1'b1;
      tick(4);
      total++;
      if (dut.u_anim.fish_x !== 9'd0 || dut.u_anim.frame_idx !== 3'd0) begin
         bad++; $display("FAIL motion_mid got x=%0d f=%0d exp x=0 f=0", dut.u_anim.fish_x, dut.u_anim.frame_idx);
      end
      tick(4);
      total++;
      if (dut.u_anim.fish_x !== 9'd1 || dut.u_anim.frame_idx !== 3'd1) begin
         bad++; $display("FAIL motion_8 got x=%0d f=%0d exp x=1 f=1", dut.u_anim.fish_x, dut.u_anim.frame_idx);
      end
      cyc(10, 130, 1'b1, 12'h000);
      total++;
      if (bus.sram_addr !== 16'd2116) begin bad++; $display("FAIL motion_addr got %0d exp 2116", bus.sram_addr); end
      tick(56);
      total++;
      if (dut.u_anim.fish_x !== 9'd8 || dut.u_anim.frame_idx !== 3'd0) begin
         bad++; $display("FAIL motion_64 got x=%0d f=%0d exp x=8 f=0", dut.u_anim.fish_x, dut.u_anim.frame_idx);
      end
   endtask

   task automatic test_wrap;
      tick(2336);
      total++;
      if (dut.u_anim.fish_x !== 9'd300 || dut.u_anim.frame_idx !== 3'd4) begin
         bad++; $display("FAIL wrap_300 got x=%0d f=%0d exp x=300 f=4", dut.u_anim.fish_x, dut.u_anim.frame_idx);
      end
      cyc(8, 128, 1'b1, 12'h0AA);
      total++;
      if (bus.sram_addr !== 16'd8216) begin bad++; $display("FAIL wrap_addr got %0d exp 8216", bus.sram_addr); end
      cyc(638, 128, 1'b1, 12'h0BB);
      total++;
      if (bus.sram_addr !== 16'd8211) begin bad++; $display("FAIL wrap_right got %0d exp 8211", bus.sram_addr); end
      cyc(0, 0, 1'b0, 12'h000);
      total++;
      if (bus.rgb_o !== 12'hF18) begin bad++; $display("FAIL wrap_rgb got %h exp F18", bus.rgb_o); end
      tick(152);
      total++;
      if (dut.u_anim.fish_x !== 9'd319 || dut.u_anim.frame_idx !== 3'd7) begin
         bad++; $display("FAIL wrap_319 got x=%0d f=%0d exp x=319 f=7", dut.u_anim.fish_x, dut.u_anim.frame_idx);
      end
      cyc(124, 190, 1'b1, 12'h000);
      total++;
      if (bus.sram_addr !== 16'd16383) begin bad++; $display("FAIL max_addr got %0d exp 16383", bus.sram_addr); end
      tick(7);
      total++;
      if (dut.u_anim.fish_x !== 9'd319) begin bad++; $display("FAIL wrap_hold got x=%0d exp 319", dut.u_anim.fish_x); end
      tick(1);
      total++;
      if (dut.u_anim.fish_x !== 9'd0 || dut.u_anim.frame_idx !== 3'd0) begin
         bad++; $display("FAIL wrap_0 got x=%0d f=%0d exp x=0 f=0", dut.u_anim.fish_x, dut.u_anim.frame_idx);
      end
   endtask

   task automatic test_reset_mid;
      tick(8);
      cyc(10, 130, 1'b1, 12'h0CC);
      cyc(10, 130, 1'b1, 12'h0CC);
      cyc(10, 130, 1'b1, 12'h0CC);
      total++;
      if (bus.rgb_o !== 12'hF44 || bus.sram_addr !== 16'd2116) begin
         bad++; $display("FAIL pre_reset got rgb=%h addr=%0d exp F44/2116", bus.rgb_o, bus.sram_addr);
      end
      reset_n = 1'b0;
      #1;
      total++;
      if (bus.rgb_o !== 12'h000 || bus.video_on_o !== 1'b0 || bus.sram_addr !== 16'd0) begin
         bad++; $display("FAIL mid_reset got rgb=%h vo=%b addr=%0d exp 000/0/0", bus.rgb_o, bus.video_on_o, bus.sram_addr);
      end
      total++;
      if (dut.u_anim.fish_x !== 9'd0 || dut.u_anim.frame_idx !== 3'd0) begin
         bad++; $display("FAIL mid_reset_motion got x=%0d f=%0d exp 0/0", dut.u_anim.fish_x, dut.u_anim.frame_idx);
      end
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      run = 1'b0;
      cyc(10, 130, 1'b1, 12'h000);
      total++;
      if (bus.sram_addr !== 16'd69) begin bad++; $display("FAIL post_reset_addr got %0d exp 69", bus.sram_addr); end
   endtask

   initial begin
      for (int i = 0; i < 16384; i++) mem[i] = tex(i);
      bus.pixel_x  = '0;
      bus.pixel_y  = '0;
      bus.video_on = 1'b0;
      bus.bg_rgb   = '0;
      test_reset();
      test_hit_addr();
      test_back_to_back();
      test_freeze();
      test_motion();
      test_wrap();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
